// File: rtl/tiny16_pkg.sv
// tiny16 shared definitions: opcodes, FSM states,
// instruction field positions and error codes.
package tiny16_pkg;

  localparam int NREGS = 8;
  localparam int DW    = 16;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_MUL = 4'h5;
  localparam logic [3:0] OP_DIV = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;
  localparam int AR_BIT = 2;
  localparam int IMM_HI = 8;
  localparam int IMM_LO = 0;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction issue handshake between a producer
// and the tiny16 issue controller.
interface alu_issue_ctrl_if;
  import tiny16_pkg::*;

  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );

endinterface

// File: rtl/tiny16_regfile.sv
// 8x16 register file, R0 reads as zero, two operand
// read ports, a debug read port and one write port.
module tiny16_regfile
  import tiny16_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    rs1_addr,
  input  logic [2:0]    rs2_addr,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [DW-1:0] dbg_data,
  input  logic          we,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wr_addr != 3'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rs1_data = (rs1_addr == 3'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 3'd0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue decode/execute/writeback controller
// sitting in front of the tiny16 ALU.
module alu_issue_ctrl
  import tiny16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_issue_ctrl_if.slave  bus,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [3:0]       status,
  output logic [3:0]       alu_opcode,
  output logic             alu_ar_flag,
  output logic [DW-1:0]    alu_src1,
  output logic [DW-1:0]    alu_src2,
  output logic             alu_out_en,
  input  logic [DW-1:0]    alu_out,
  input  logic [3:0]       alu_flags,
  input  logic [2:0]       dbg_addr,
  output logic [DW-1:0]    dbg_data
);

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] ir;
  logic          err_q;
  logic          err_n;
  logic [1:0]    code_q;
  logic [1:0]    code_n;
  logic          accept;

  logic [3:0]    in_op;
  logic [3:0]    ir_op;
  logic [2:0]    rs1_a;
  logic [2:0]    rs2_a;
  logic [DW-1:0] rs1_d;
  logic [DW-1:0] rs2_d;
  logic          we;
  logic [DW-1:0] wr_d;

  logic          in_simple;
  logic          in_div0;
  logic          in_alu;
  logic          wb_alu;

  assign in_op = bus.instr[OPC_HI:OPC_LO];
  assign ir_op = ir[OPC_HI:OPC_LO];

  // In IDLE rs2 looks at the incoming word for the divide-by-zero check
  assign rs1_a = ir[RS1_HI:RS1_LO];
  assign rs2_a = (state == S_IDLE) ? bus.instr[RS2_HI:RS2_LO]
                                   : ir[RS2_HI:RS2_LO];

  assign in_simple = (in_op == OP_NOP) || (in_op == OP_LDI);
  assign in_div0   = (in_op == OP_DIV) && (rs2_d == '0);
  assign in_alu    = is_alu_op(in_op) && !in_div0;
  assign wb_alu    = (state == S_WB) && is_alu_op(ir_op);

  tiny16_regfile u_rf (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_a),
    .rs2_addr (rs2_a),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_d),
    .rs2_data (rs2_d),
    .dbg_data (dbg_data),
    .we       (we),
    .wr_addr  (ir[RD_HI:RD_LO]),
    .wr_data  (wr_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      ir     <= '0;
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
      status <= '0;
    end else begin
      state  <= state_n;
      err_q  <= err_n;
      code_q <= code_n;
      if (accept) begin
        ir <= bus.instr;
      end
      if (wb_alu) begin
        status <= alu_flags;
      end
    end
  end

  always_comb begin
    state_n         = state;
    err_n           = 1'b0;
    code_n          = ERR_NONE;
    accept          = 1'b0;
    bus.instr_ready = 1'b0;
    done            = 1'b0;
    alu_out_en      = 1'b0;
    alu_opcode      = '0;
    alu_ar_flag     = 1'b0;
    alu_src1        = '0;
    alu_src2        = '0;
    we              = 1'b0;
    wr_d            = '0;
    unique case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept = 1'b1;
          unique case (1'b1)
            in_simple: state_n = S_WB;
            in_alu:    state_n = S_EXEC;
            in_div0: begin
              err_n  = 1'b1;
              code_n = ERR_DIV0;
            end
            default: begin
              err_n  = 1'b1;
              code_n = ERR_ILLEGAL;
            end
          endcase
        end
      end
      S_EXEC: begin
        alu_out_en  = 1'b1;
        alu_opcode  = ir_op;
        alu_ar_flag = ir[AR_BIT];
        alu_src1    = rs1_d;
        alu_src2    = rs2_d;
        state_n     = S_WB;
      end
      S_WB: begin
        done    = 1'b1;
        state_n = S_IDLE;
        if (is_alu_op(ir_op)) begin
          we   = 1'b1;
          wr_d = alu_out;
        end else if (ir_op == OP_LDI) begin
          we   = 1'b1;
          wr_d = {{(DW-9){1'b0}}, ir[IMM_HI:IMM_LO]};
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stand-in, instruction-level
// reference model, per-cycle compare and directed vectors.
module tb_alu_issue_ctrl;
  import tiny16_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done, err, alu_ar_flag, alu_out_en;
  logic [1:0]  err_code;
  logic [3:0]  status, alu_opcode;
  logic [3:0]  alu_flags = '0;
  logic [15:0] alu_src1, alu_src2, dbg_data;
  logic [15:0] alu_out = '0;
  logic [2:0]  dbg_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .status      (status),
    .alu_opcode  (alu_opcode),
    .alu_ar_flag (alu_ar_flag),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_out_en  (alu_out_en),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ALU stand-in; returns {O,C,N,Z,result}. O mirrors carry/borrow here.
  function automatic logic [19:0] alu_calc(input logic [3:0] op,
      input logic ar, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic        c;
    w = '0; p = '0; r = '0; c = 1'b0;
    case (op)
      OP_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16]; end
      OP_SUB: begin w = {1'b0, a} - {1'b0, b}; r = w[15:0]; c = w[16]; end
      OP_MUL: begin p = a * b; r = p[15:0]; end
      OP_DIV: r = (b == 16'd0) ? 16'hFFFF : a / b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: r = a << b[3:0];
      OP_SHR: r = ar ? 16'($signed(a) >>> b[3:0]) : (a >> b[3:0]);
      default: r = '0;
    endcase
    return {c, c, r[15], (r == 16'd0), r};
  endfunction

  always @(posedge clk) begin
    if (alu_out_en) begin
      {alu_flags, alu_out} <= alu_calc(alu_opcode, alu_ar_flag,
                                       alu_src1, alu_src2);
    end
  end

  // Reference model: m_left = cycles until the in-flight word retires
  logic [15:0] m_regs [8] = '{default: '0};
  logic [3:0]  m_status = '0;
  int          m_left = 0;
  logic        m_errp = 1'b0;
  logic [1:0]  m_code = '0;
  logic [15:0] m_instr = '0;
  logic [19:0] m_res = '0;

  always @(posedge clk) begin
    logic [3:0] op;
    logic [2:0] rd;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_status = '0; m_left = 0; m_errp = 1'b0; m_code = '0;
    end else begin
      m_errp = 1'b0;
      m_code = '0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          op = m_instr[15:12];
          rd = m_instr[11:9];
          if (op == OP_LDI && rd != 3'd0)
            m_regs[rd] = {7'd0, m_instr[8:0]};
          if (op >= OP_ADD && op <= OP_SHR) begin
            if (rd != 3'd0) m_regs[rd] = m_res[15:0];
            m_status = m_res[19:16];
          end
        end
      end else if (bus.instr_valid) begin
        op = bus.instr[15:12];
        if (op == 4'h2 || op >= 4'hC) begin
          m_errp = 1'b1; m_code = 2'b01;
        end else if (op == OP_DIV && m_regs[bus.instr[5:3]] == 16'd0) begin
          m_errp = 1'b1; m_code = 2'b10;
        end else begin
          m_instr = bus.instr;
          m_left  = (op <= OP_LDI) ? 1 : 2;
          m_res   = alu_calc(op, bus.instr[2], m_regs[bus.instr[8:6]],
                             m_regs[bus.instr[5:3]]);
        end
      end
    end
  end

  int         done_cnt = 0;
  int         err_cnt = 0;
  int         en_cnt = 0;
  int         last_done_cyc = 0;
  logic [1:0] last_code = '0;

  always @(negedge clk) begin
    logic [37:0] exp_bus;
    if (cyc >= 1) begin
      exp_bus = '0;
      if (m_left == 2)
        exp_bus = {1'b1, m_instr[15:12], m_instr[2],
                   m_regs[m_instr[8:6]], m_regs[m_instr[5:3]]};
      chk("ready", 64'(bus.instr_ready), 64'(m_left == 0));
      chk("done", 64'(done), 64'(m_left == 1));
      chk("err", 64'(err), 64'(m_errp));
      chk("err_code", 64'(err_code), 64'(m_code));
      chk("alu_bus", 64'({alu_out_en, alu_opcode, alu_ar_flag,
                          alu_src1, alu_src2}), 64'(exp_bus));
      chk("status", 64'(status), 64'(m_status));
      chk("dbg_data", 64'(dbg_data), 64'(m_regs[dbg_addr]));
    end
    if (done) begin done_cnt++; last_done_cyc = cyc; end
    if (err) begin err_cnt++; last_code = err_code; end
    if (alu_out_en) en_cnt++;
  end

  function automatic logic [15:0] enc(input logic [3:0] op,
      input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2,
      input logic ar);
    return {op, rd, s1, s2, ar, 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd,
                                      input logic [8:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  int acc_cyc = 0;

  task automatic issue(input logic [15:0] w, input bit hold);
    bit rdy;
    int t;
    rdy = 1'b0;
    t = 0;
    bus.instr_valid = 1'b1;
    bus.instr = w;
    while (!rdy && t < 20) begin
      @(negedge clk);
      rdy = bus.instr_ready;
      if (rdy) acc_cyc = cyc;
      @(posedge clk);
      #2;
      t++;
      dbg_addr = dbg_addr + 3'd1;
    end
    if (!hold) bus.instr_valid = 1'b0;
    if (!rdy) chk("accept_timeout", 64'(rdy), 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic lit_reg(input string nm, input logic [2:0] r,
                         input logic [15:0] e);
    dbg_addr = r;
    #1;
    chk(nm, 64'(dbg_data), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    dbg_addr = '0;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.instr_ready), 64'd1);
    chk("rst_status", 64'(status), 64'd0);
    chk("rst_alu_en", 64'(alu_out_en), 64'd0);

    issue(ldi(3'd1, 9'd5), 1'b0);
    a0 = acc_cyc;
    step(2);
    chk("ldi_latency", 64'(last_done_cyc - a0), 64'd1);
    issue(ldi(3'd2, 9'd3), 1'b0);
    issue(enc(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0), 1'b0);
    a0 = acc_cyc;
    step(3);
    chk("add_latency", 64'(last_done_cyc - a0), 64'd2);
    lit_reg("add_r3", 3'd3, 16'h0008);
    chk("add_status", 64'(status), 64'h0);

    en_cnt = 0;
    issue(enc(OP_SUB, 3'd4, 3'd2, 3'd1, 1'b0), 1'b0);
    step(3);
    chk("sub_en_cycles", 64'(en_cnt), 64'd1);
    lit_reg("sub_r4", 3'd4, 16'hFFFE);
    chk("sub_status", 64'(status), 64'hE);

    en_cnt = 0;
    err_cnt = 0;
    issue(enc(OP_DIV, 3'd5, 3'd1, 3'd0, 1'b0), 1'b0);
    step(2);
    chk("div0_err", 64'(err_cnt), 64'd1);
    chk("div0_code", 64'(last_code), 64'h2);
    chk("div0_en", 64'(en_cnt), 64'd0);
    lit_reg("div0_r5", 3'd5, 16'h0000);
    chk("div0_status", 64'(status), 64'hE);

    err_cnt = 0;
    done_cnt = 0;
    issue(16'hF000, 1'b0);
    a1 = acc_cyc;
    issue(ldi(3'd0, 9'h1FF), 1'b0);
    a2 = acc_cyc;
    step(2);
    chk("ill_err", 64'(err_cnt), 64'd1);
    chk("ill_code", 64'(last_code), 64'h1);
    chk("ill_next_accept", 64'(a2 - a1), 64'd1);
    chk("ldi_r0_done", 64'(done_cnt), 64'd1);
    lit_reg("ldi_r0", 3'd0, 16'h0000);

    issue(enc(OP_MUL, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);
    issue(enc(OP_DIV, 3'd7, 3'd6, 3'd2, 1'b0), 1'b0);
    issue(enc(OP_AND, 3'd6, 3'd4, 3'd1, 1'b0) | 16'h0003, 1'b0);
    issue(enc(OP_OR, 3'd6, 3'd6, 3'd2, 1'b1), 1'b0);
    issue(enc(OP_XOR, 3'd6, 3'd6, 3'd4, 1'b0), 1'b0);
    issue(enc(OP_SHL, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);
    issue(enc(OP_NOP, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);
    step(2);
    lit_reg("shl_r6", 3'd6, 16'h0028);
    lit_reg("div_r7", 3'd7, 16'h0005);
    issue(enc(OP_SHR, 3'd6, 3'd4, 3'd2, 1'b1), 1'b0);
    step(3);
    lit_reg("sra_r6", 3'd6, 16'hFFFF);
    issue(enc(OP_SHR, 3'd6, 3'd4, 3'd2, 1'b0), 1'b0);
    step(3);
    lit_reg("srl_r6", 3'd6, 16'h1FFF);

    issue(enc(OP_ADD, 3'd5, 3'd5, 3'd1, 1'b0), 1'b1);
    a0 = acc_cyc;
    issue(enc(OP_ADD, 3'd5, 3'd5, 3'd1, 1'b1), 1'b1);
    a1 = acc_cyc;
    issue(enc(OP_ADD, 3'd5, 3'd5, 3'd1, 1'b0), 1'b0);
    a2 = acc_cyc;
    step(4);
    chk("b2b_gap1", 64'(a1 - a0), 64'd3);
    chk("b2b_gap2", 64'(a2 - a1), 64'd3);
    lit_reg("b2b_r5", 3'd5, 16'h000F);

    done_cnt = 0;
    issue(enc(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    #1;
    chk("rst_exec_ready", 64'(bus.instr_ready), 64'd1);
    step(3);
    chk("rst_exec_done", 64'(done_cnt), 64'd0);
    lit_reg("rst_exec_r6", 3'd6, 16'h0000);
    lit_reg("rst_exec_r1", 3'd1, 16'h0000);
    chk("rst_exec_status", 64'(status), 64'h0);

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
